// File: rtl/dp_ram_be.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency, write-first collisions and a zero-fill sweep after reset.
// Optional per-byte even parity with error injection is enabled by defining DP_RAM_PARITY_EN.
module dp_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_par_flip,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    rd_err,
    output logic                    init_busy
);

    // state | meaning
    // CLEAR | zero-fill sweep running, all requests ignored
    // READY | normal read/write operation

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   sweep_cnt;
    logic [ADDR_WIDTH-1:0] sweep_idx;
    logic                  sweep_we;
    logic                  wr_go;
    logic                  rd_go;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [NB-1:0]         byte_err;
    logic                  rd_perr;
    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data;
    logic                  pipe_err;

    assign sweep_idx   = sweep_cnt[ADDR_WIDTH-1:0];
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
    assign init_busy   = (state == CLEAR);
    assign rd_perr     = |byte_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
        end else begin
            state <= state_next;
            if (sweep_we) begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        sweep_we   = 1'b0;
        wr_go      = 1'b0;
        rd_go      = 1'b0;
        case (state)
            CLEAR: begin
                sweep_we = 1'b1;
                if (sweep_cnt == LAST_IDX) begin
                    state_next = READY;
                end
            end
            READY: begin
                wr_go = wr_en && wr_in_range && (|wr_be);
                rd_go = rd_en;
            end
            default: state_next = CLEAR;
        endcase
    end

    // One bank per byte lane; a same-address write in the read cycle bypasses the bank.
    for (genvar b = 0; b < NB; b++) begin : g_byte
        logic [7:0] bank [DEPTH];
        logic [7:0] wbyte;
        logic       hit;

        assign wbyte = wr_data[8*b +: 8];
        assign hit   = wr_go && wr_be[b] && (wr_addr == rd_addr);

        always_ff @(posedge clk) begin
            if (sweep_we) begin
                bank[sweep_idx] <= '0;
            end else if (wr_go && wr_be[b]) begin
                bank[wr_addr] <= wbyte;
            end
        end

        assign rd_word[8*b +: 8] = !rd_in_range ? 8'h00 :
                                   hit          ? wbyte : bank[rd_addr];

`ifdef DP_RAM_PARITY_EN
        logic par_bank [DEPTH];
        logic pbit;

        always_ff @(posedge clk) begin
            if (sweep_we) begin
                par_bank[sweep_idx] <= 1'b0;
            end else if (wr_go && wr_be[b]) begin
                par_bank[wr_addr] <= (^wbyte) ^ wr_par_flip[b];
            end
        end

        assign pbit        = hit ? ((^wbyte) ^ wr_par_flip[b]) : par_bank[rd_addr];
        assign byte_err[b] = rd_in_range && ((^rd_word[8*b +: 8]) ^ pbit);
`else
        assign byte_err[b] = 1'b0;
`endif
    end

`ifndef DP_RAM_PARITY_EN
    logic unused_par_flip;
    assign unused_par_flip = ^wr_par_flip;
`endif

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  s1_valid;
        logic [DATA_WIDTH-1:0] s1_data;
        logic                  s1_err;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid <= 1'b0;
                s1_data  <= '0;
                s1_err   <= 1'b0;
            end else begin
                s1_valid <= rd_go;
                if (rd_go) begin
                    s1_data <= rd_word;
                    s1_err  <= rd_perr;
                end
            end
        end

        assign pipe_valid = s1_valid;
        assign pipe_data  = s1_data;
        assign pipe_err   = s1_err;
    end else begin : g_lat1
        assign pipe_valid = rd_go;
        assign pipe_data  = rd_word;
        assign pipe_err   = rd_perr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= pipe_valid;
            rd_err   <= pipe_valid && pipe_err;
            if (pipe_valid) begin
                rd_data <= pipe_data;
            end
        end
    end

endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be: a full-depth latency-1 RAM and a 200-word latency-2 RAM share one stimulus stream
// and are compared against a word/byte-level reference model.
module tb_dp_ram_be;

    localparam int D2 = 200;
`ifdef DP_RAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_be = '0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_par_flip = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;

    logic [31:0] rd_data1, rd_data2;
    logic        rd_valid1, rd_valid2, rd_err1, rd_err2, init_busy1, init_busy2;

    dp_ram_be dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_par_flip(wr_par_flip), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_err(rd_err1), .init_busy(init_busy1)
    );

    dp_ram_be #(.DEPTH(D2), .RD_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_par_flip(wr_par_flip), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_err(rd_err2), .init_busy(init_busy2)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [31:0] m_mem [256];
    logic [3:0]  m_bad [256];
    logic        prev_re;
    logic [31:0] prev_d2;
    logic        prev_e2;
    logic [31:0] last1, last2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = '0;
            m_bad[i] = '0;
        end
        prev_re = 1'b0;
        prev_d2 = '0;
        prev_e2 = 1'b0;
        last1   = '0;
        last2   = '0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid1"}, 32'(rd_valid1), 32'(0));
        check({tag, "_valid2"}, 32'(rd_valid2), 32'(0));
        check({tag, "_data1"}, rd_data1, 32'h0);
        check({tag, "_data2"}, rd_data2, 32'h0);
        check({tag, "_err1"}, 32'(rd_err1), 32'(0));
        check({tag, "_busy1"}, 32'(init_busy1), 32'(1));
        check({tag, "_busy2"}, 32'(init_busy2), 32'(1));
    endtask

    // Sweep edges 1..stop_at from reset release; noise requests must be ignored while clearing.
    task automatic run_sweep(input int stop_at);
        for (int n = 1; n <= stop_at; n++) begin
            if (n <= D2) begin
                wr_en = 1'($urandom); wr_be = 4'($urandom); wr_addr = 8'($urandom);
                wr_data = $urandom; wr_par_flip = 4'($urandom);
                rd_en = 1'($urandom); rd_addr = 8'($urandom);
            end else begin
                wr_en = 1'b0; rd_en = 1'b0;
            end
            @(posedge clk); #1;
            check("sweep_busy1", 32'(init_busy1), 32'(n < 256));
            check("sweep_busy2", 32'(init_busy2), 32'(n < D2));
            check("sweep_valid1", 32'(rd_valid1), 32'(0));
            check("sweep_valid2", 32'(rd_valid2), 32'(0));
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        prev_re = 1'b0;
    endtask

    // One READY cycle: drive at negedge, predict, clock, compare both RAMs.
    task automatic step(input logic we, input logic [3:0] be, input logic [7:0] wa, input logic [31:0] wd,
                        input logic re, input logic [7:0] ra, input logic [3:0] flip);
        logic [31:0] e;
        logic [3:0]  eb;
        logic        err1, err2;
        logic [31:0] e2;
        wr_en = we; wr_be = be; wr_addr = wa; wr_data = wd; wr_par_flip = flip;
        rd_en = re; rd_addr = ra;
        for (int i = 0; i < 4; i++) begin
            if (we && be[i] && wa == ra) begin
                e[8*i +: 8] = wd[8*i +: 8];
                eb[i] = flip[i];
            end else begin
                e[8*i +: 8] = m_mem[ra][8*i +: 8];
                eb[i] = m_bad[ra][i];
            end
        end
        err1 = PAR_EN && (|eb);
        e2   = (ra < D2) ? e : 32'h0;
        err2 = (ra < D2) && err1;
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    m_mem[wa][8*i +: 8] = wd[8*i +: 8];
                    m_bad[wa][i] = flip[i];
                end
            end
        end
        @(posedge clk); #1;
        check("busy1", 32'(init_busy1), 32'(0));
        check("busy2", 32'(init_busy2), 32'(0));
        check("valid1", 32'(rd_valid1), 32'(re));
        if (re) begin
            check("data1", rd_data1, e);
            check("err1", 32'(rd_err1), 32'(err1));
            last1 = e;
        end else begin
            check("hold1", rd_data1, last1);
        end
        check("valid2", 32'(rd_valid2), 32'(prev_re));
        if (prev_re) begin
            check("data2", rd_data2, prev_d2);
            check("err2", 32'(rd_err2), 32'(prev_e2));
            last2 = prev_d2;
        end else begin
            check("hold2", rd_data2, last2);
        end
        prev_re = re; prev_d2 = e2; prev_e2 = err2;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, 4'h0);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, a, 4'h0);
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 2))
            0:       return 8'($urandom_range(0, 7));
            1:       return 8'($urandom_range(196, 203));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        run_sweep(256);

        rd(8'h00);
        rd(8'hFF);
        step(1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00, 4'h0);
        step(1'b1, 4'b0101, 8'h10, 32'h11223344, 1'b0, 8'h00, 4'h0);
        rd(8'h10);
        step(1'b1, 4'h0, 8'h10, 32'hFFFFFFFF, 1'b1, 8'h10, 4'h0);
        step(1'b1, 4'hF, 8'h20, 32'hCAFEF00D, 1'b1, 8'h20, 4'h0);
        step(1'b1, 4'b0001, 8'h24, 32'hCAFEF00D, 1'b1, 8'h24, 4'h0);
        idle();

        for (int i = 0; i < 8; i++) step(1'b1, 4'hF, 8'(i), $urandom, 1'b0, 8'h00, 4'h0);
        for (int i = 0; i < 8; i++) rd(8'(i));
        idle();
        idle();

        step(1'b1, 4'hF, 8'hD0, 32'h12345678, 1'b0, 8'h00, 4'h0);
        step(1'b1, 4'hF, 8'hC7, 32'h87654321, 1'b1, 8'hD0, 4'h0);
        rd(8'hC7);
        step(1'b1, 4'hF, 8'hC8, 32'hA5A5A5A5, 1'b1, 8'hC8, 4'h0);
        rd(8'h40);
        step(1'b1, 4'hF, 8'h40, 32'h5A5A5A5A, 1'b0, 8'h00, 4'h0);
        rd(8'h40);
        idle();

`ifdef DP_RAM_PARITY_EN
        step(1'b1, 4'hF, 8'h30, 32'h000000FF, 1'b0, 8'h00, 4'b0001);
        rd(8'h30);
        step(1'b1, 4'hF, 8'h30, 32'h000000FF, 1'b0, 8'h00, 4'b0000);
        rd(8'h30);
        step(1'b1, 4'b0010, 8'h31, 32'h0000AB00, 1'b1, 8'h31, 4'b0010);
        idle();
`endif

        repeat (400) begin
            step(1'($urandom_range(0, 9) < 6), 4'($urandom), pick_addr(), $urandom,
                 1'($urandom_range(0, 9) < 6), pick_addr(), ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
        end
        idle();
        idle();

        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'h10;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid_read");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(256);
        rd(8'h10);
        rd(8'h05);
        idle();
        idle();

        step(1'b1, 4'hF, 8'h64, 32'h0BADF00D, 1'b0, 8'h00, 4'h0);
        rst_n = 1'b0;
        #1;
        check_reset("rst_ready");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(100);
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid_sweep");
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(256);
        rd(8'h64);
        rd(8'h00);
        rd(8'hFF);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
